// File: rtl/array_sequencer.sv
// rtl/array_sequencer.sv - operand buffers and FEED/DRAIN sequencing for a rows x cols systolic array
// Defining ARRAY_SEQ_PERF_EN adds the saturating busy-cycle counter on perf_cycles.
module array_sequencer #(
  parameter int width   = 8,
  parameter int decimal = 4,
  parameter int rows    = 3,
  parameter int cols    = 4,
  parameter int depth   = 4,
  localparam int aw     = $clog2(depth),
  localparam int raw    = (rows > 1) ? $clog2(rows) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [aw-1:0]           wr_addr,
  input  logic [cols*width-1:0]   wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [rows*cols-1:0]    ctls,
  output logic [cols*width-1:0]   ins,
  output logic [rows*width-1:0]   ws,
  input  logic [cols*width-1:0]   outs,
  input  logic [raw-1:0]          rd_addr,
  output logic [cols*width-1:0]   rd_data,
  output logic [15:0]             perf_cycles
);

  localparam int feed_len = depth + rows + cols - 2;
  localparam int cw       = $clog2(feed_len + 1);

  if (depth < 2 || (depth & (depth - 1)) != 0 || decimal >= width || rows > cols) begin : g_param_check
    $error("array_sequencer: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                state, state_n;
  logic [cw-1:0]         cnt, cnt_n;
  logic [cols*width-1:0] in_buf [depth];
  logic [rows*width-1:0] w_buf  [depth];
  logic [cols*width-1:0] res    [rows];
  logic                  wr_ok;
  logic [cols*width-1:0] ins_n, in_word;
  logic [rows*width-1:0] ws_n, w_word;
  logic [rows*cols-1:0]  ctls_n;
  int                    k;

  assign wr_ok = wr_en && (state == IDLE);

  // Operand buffers deliberately survive reset so a run can be replayed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) w_buf[wr_addr] <= wr_data[rows*width-1:0];
      else        in_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      IDLE:    if (start) state_n = FEED;
      FEED:    if (cnt == cw'(feed_len - 1)) state_n = DRAIN;
               else cnt_n = cnt + 1'b1;
      DRAIN:   if (cnt == cw'(rows - 1)) state_n = DONE;
               else cnt_n = cnt + 1'b1;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Skewed operand selection for the coming cycle; a write on the start edge is forwarded.
  always_comb begin
    ins_n   = '0;
    ws_n    = '0;
    ctls_n  = '0;
    in_word = '0;
    w_word  = '0;
    k       = 0;
    if (state_n == FEED) begin
      for (int c = 0; c < cols; c++) begin
        k = int'(cnt_n) - c;
        if (k >= 0 && k < depth) begin
          in_word = in_buf[aw'(k)];
          if (wr_ok && !wr_sel && wr_addr == aw'(k)) in_word = wr_data;
          ins_n[c*width +: width] = in_word[c*width +: width];
        end
      end
      for (int r = 0; r < rows; r++) begin
        k = int'(cnt_n) - r;
        if (k >= 0 && k < depth) begin
          w_word = w_buf[aw'(k)];
          if (wr_ok && wr_sel && wr_addr == aw'(k)) w_word = wr_data[rows*width-1:0];
          ws_n[r*width +: width] = w_word[r*width +: width];
        end
        for (int c = 0; c < cols; c++)
          ctls_n[r*cols + c] = int'(cnt_n) >= depth + r + c;
      end
    end else if (state_n == DRAIN) begin
      ctls_n = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      ctls <= '0;
      ins  <= '0;
      ws   <= '0;
      for (int r = 0; r < rows; r++) res[r] <= '0;
    end else begin
      busy <= (state_n == FEED) || (state_n == DRAIN);
      done <= (state_n == DONE);
      ctls <= ctls_n;
      ins  <= ins_n;
      ws   <= ws_n;
      if (state == DRAIN)
        for (int r = 0; r < rows; r++)
          if (cnt == cw'(r)) res[r] <= outs;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < rows; r++)
      if (rd_addr == raw'(r)) rd_data = res[r];
  end

`ifdef ARRAY_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst)                          perf_q <= '0;
    else if (state == IDLE && start)   perf_q <= '0;
    else if (busy && perf_q != 16'hFFFF) perf_q <= perf_q + 1'b1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_array_sequencer.sv
// tb/tb_array_sequencer.sv - randomized self-checking bench for array_sequencer with an attached array model
module tb_array_sequencer;

  localparam int W   = 8;
  localparam int DEC = 4;
  localparam int R   = 3;
  localparam int C   = 4;
  localparam int D   = 4;
  localparam int F   = D + R + C - 2;
`ifdef ARRAY_SEQ_PERF_EN
  localparam logic [15:0] PERF_RUN = 16'd12;
`else
  localparam logic [15:0] PERF_RUN = 16'd0;
`endif

  logic           clk = 1'b0;
  logic           rst, wr_en, wr_sel, start;
  logic [1:0]     wr_addr, rd_addr;
  logic [C*W-1:0] wr_data, ins, outs, rd_data;
  logic           busy, done;
  logic [R*C-1:0] ctls;
  logic [R*W-1:0] ws;
  logic [15:0]    perf_cycles;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] in_m [D][C];
  logic [W-1:0] w_m  [D][R];
  logic [W-1:0] acc   [R][C];
  logic [W-1:0] a_reg [R][C];
  logic [W-1:0] b_reg [R][C];

  always #5 clk = ~clk;

  array_sequencer #(.width(W), .decimal(DEC), .rows(R), .cols(C), .depth(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .ctls(ctls),
    .ins(ins), .ws(ws), .outs(outs), .rd_addr(rd_addr), .rd_data(rd_data),
    .perf_cycles(perf_cycles)
  );

  // Systolic array: data moves down, weights move right, all-shift drains rows toward row 0.
  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return W'(p >>> DEC);
  endfunction

  function automatic logic [W-1:0] pe_a(input int r, input int c);
    if (r == 0) return ins[c*W +: W];
    return a_reg[r-1][c];
  endfunction

  function automatic logic [W-1:0] pe_b(input int r, input int c);
    if (c == 0) return ws[r*W +: W];
    return b_reg[r][c-1];
  endfunction

  function automatic logic [W-1:0] below(input int r, input int c);
    if (r == R - 1) return '0;
    return acc[r+1][c];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (!rst) begin
          acc[r][c]   <= '0;
          a_reg[r][c] <= '0;
          b_reg[r][c] <= '0;
        end else begin
          a_reg[r][c] <= pe_a(r, c);
          b_reg[r][c] <= pe_b(r, c);
          if (&ctls) acc[r][c] <= below(r, c);
          else if (!ctls[r*C + c]) acc[r][c] <= acc[r][c] + fx_mul(pe_a(r, c), pe_b(r, c));
        end
  end

  always_comb begin
    outs = '0;
    for (int c = 0; c < C; c++) outs[c*W +: W] = acc[0][c];
  end

  // Reference: matrix product of the operand tables, plus the skew rules per step.
  function automatic logic [C*W-1:0] exp_row(input int r);
    logic [C*W-1:0] v;
    int s;
    v = '0;
    if (r < R)
      for (int c = 0; c < C; c++) begin
        s = 0;
        for (int k = 0; k < D; k++)
          s += (int'($signed(in_m[k][c])) * int'($signed(w_m[k][r]))) >>> DEC;
        v[c*W +: W] = W'(s);
      end
    return v;
  endfunction

  function automatic logic [C*W-1:0] exp_ins(input int t);
    logic [C*W-1:0] v;
    v = '0;
    for (int c = 0; c < C; c++)
      if (t - c >= 0 && t - c < D) v[c*W +: W] = in_m[t-c][c];
    return v;
  endfunction

  function automatic logic [R*W-1:0] exp_ws(input int t);
    logic [R*W-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++)
      if (t - r >= 0 && t - r < D) v[r*W +: W] = w_m[t-r][r];
    return v;
  endfunction

  function automatic logic [R*C-1:0] exp_ctls(input int t);
    logic [R*C-1:0] v;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) v[r*C + c] = (t >= D + r + c);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    logic [C*W-1:0] d;
    for (int k = 0; k < D; k++) begin
      for (int c = 0; c < C; c++) d[c*W +: W] = in_m[k][c];
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'(k); wr_data = d;
      step();
      d = $urandom;
      for (int r = 0; r < R; r++) d[r*W +: W] = w_m[k][r];
      wr_sel = 1'b1; wr_data = d;
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < D; k++) begin
      for (int c = 0; c < C; c++) in_m[k][c] = W'($urandom);
      for (int r = 0; r < R; r++) w_m[k][r]  = W'($urandom);
    end
  endtask

  task automatic check_results(input string name);
    logic [C*W-1:0] e;
    for (int r = 0; r <= R; r++) begin
      rd_addr = 2'(r);
      #1;
      e = exp_row(r);
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL %s result row %0d: got %h expected %h", name, r, rd_data, e);
      end
    end
    rd_addr = 2'd0;
  endtask

  // One complete run checked every cycle; poke injects ignored start/write, abort_t resets mid-FEED.
  task automatic do_run(input string name, input bit wr_with_start, input bit poke, input int abort_t);
    logic [C*W-1:0] d;
    logic [2+R*C+C*W+R*W-1:0] got, exp;
    int k;
    bit sel;
    start = 1'b1;
    if (wr_with_start) begin
      sel = 1'($urandom_range(0, 1));
      k = $urandom_range(0, D - 1);
      d = $urandom;
      wr_en = 1'b1; wr_sel = sel; wr_addr = 2'(k); wr_data = d;
      if (sel) for (int r = 0; r < R; r++) w_m[k][r] = d[r*W +: W];
      else     for (int c = 0; c < C; c++) in_m[k][c] = d[c*W +: W];
    end
    step();
    start = 1'b0;
    wr_en = 1'b0;
    for (int cyc = 1; cyc <= F + R + 2; cyc++) begin
      got = {busy, done, ctls, ins, ws};
      if (cyc <= F)
        exp = {1'b1, 1'b0, exp_ctls(cyc - 1), exp_ins(cyc - 1), exp_ws(cyc - 1)};
      else if (cyc <= F + R)
        exp = {1'b1, 1'b0, {R*C{1'b1}}, {C*W{1'b0}}, {R*W{1'b0}}};
      else
        exp = {1'b0, cyc == F + R + 1, {R*C{1'b0}}, {C*W{1'b0}}, {R*W{1'b0}}};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d {busy,done,ctls,ins,ws}: got %h expected %h", name, cyc, got, exp);
      end
      if (cyc == F + R + 1) begin
        checks++;
        if (perf_cycles !== PERF_RUN) begin
          errors++;
          $display("FAIL %s perf_cycles: got %0d expected %0d", name, perf_cycles, PERF_RUN);
        end
      end
      if (abort_t >= 0 && cyc == abort_t + 1) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
        got = {busy, done, ctls, ins, ws};
        checks++;
        if (got !== '0 || perf_cycles !== 16'd0 || rd_data !== '0) begin
          errors++;
          $display("FAIL %s abort clear: outs %h perf %0d rd %h expected all zero", name, got, perf_cycles, rd_data);
        end
        return;
      end
      start = poke && cyc >= 3 && cyc <= 6;
      wr_en = poke && cyc == F + 1;
      if (wr_en) begin
        wr_sel = 1'($urandom_range(0, 1)); wr_addr = 2'($urandom_range(0, D - 1)); wr_data = $urandom;
      end
      step();
    end
    start = 1'b0;
    wr_en = 1'b0;
    check_results(name);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if ({busy, done, ctls, ins, ws, perf_cycles} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %h expected 0", {busy, done, ctls, ins, ws, perf_cycles});
    end
    for (int r = 0; r < R; r++) begin
      rd_addr = 2'(r);
      #1;
      checks++;
      if (rd_data !== '0) begin
        errors++;
        $display("FAIL reset result row %0d: got %h expected 0", r, rd_data);
      end
    end
    rd_addr = 2'd0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_ones();
    for (int k = 0; k < D; k++) begin
      for (int c = 0; c < C; c++) in_m[k][c] = 8'h10;
      for (int r = 0; r < R; r++) w_m[k][r] = 8'h10;
    end
    load_all();
    do_run("ones", 1'b0, 1'b0, -1);
    rd_addr = 2'd1;
    #1;
    checks++;
    if (rd_data !== {C{8'h40}}) begin
      errors++;
      $display("FAIL ones literal row: got %h expected %h", rd_data, {C{8'h40}});
    end
    rd_addr = 2'd0;
  endtask

  task automatic test_identity();
    for (int k = 0; k < D; k++) begin
      for (int c = 0; c < C; c++) in_m[k][c] = W'(k + 1);
      for (int r = 0; r < R; r++) w_m[k][r] = (k == 0) ? 8'h10 : 8'h00;
    end
    load_all();
    do_run("identity", 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      randomize_ops();
      load_all();
      do_run("random", n[0], 1'b0, -1);
    end
  endtask

  task automatic test_ignore();
    randomize_ops();
    load_all();
    do_run("ignore", 1'b0, 1'b1, -1);
    do_run("ignore_rerun", 1'b0, 1'b0, -1);
  endtask

  task automatic test_abort();
    randomize_ops();
    load_all();
    do_run("pre_abort", 1'b0, 1'b0, -1);
    do_run("abort", 1'b0, 1'b0, 4);
    do_run("post_abort", 1'b0, 1'b0, -1);
  endtask

  task automatic test_rd_oob();
    rd_addr = 2'd3;
    #1;
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL rd_oob: got %h expected 0", rd_data);
    end
    rd_addr = 2'd0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; rd_addr = '0;
    test_reset();
    test_ones();
    test_identity();
    test_random();
    test_ignore();
    test_abort();
    test_rd_oob();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/array_sequencer.md
ARRAY_SEQUENCER -- requirements
Module: array_sequencer

Interface
REQ-001 SHALL have parameter: width, 8, fixed-point word width.
REQ-002 SHALL have parameter: decimal, 4, fractional bits (used only by verification reference model).
REQ-003 SHALL have parameter: rows, 3, array rows.
REQ-004 SHALL have parameter: cols, 4, array columns.
REQ-005 SHALL have parameter: depth, 4, reduction length K (entries per operand buffer), power of two, >=2.
REQ-006 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous, active-low reset.
  wr_en  in  1  operand buffer write strobe.
  wr_sel  in  1  0 = input buffer, 1 = weight buffer.
  wr_addr  in  clog2(depth)  buffer entry k.
  wr_data  in  cols*width  input vector; weights use low rows*width bits.
  start  in  1  begin computation (level-sampled).
  busy  out  1  high in FEED/DRAIN.
  done  out  1  one-cycle completion pulse.
  ctls  out  rows*cols  per-PE control, bit r*cols+c; 0 = MAC, 1 = shift out.
  ins  out  cols*width  column data to array row 0.
  ws  out  rows*width  row weights to array column 0.
  outs  in  cols*width  results from array row 0.
  rd_addr  in  clog2(rows)  result row select.
  rd_data  out  cols*width  result row, combinational read.
  perf_cycles  out  16  busy-cycle counter.

Function
REQ-007 SHALL implement FSM IDLE -> FEED -> DRAIN -> DONE -> IDLE.
REQ-008 In IDLE, wr_en=1 SHALL write wr_data into buffer wr_sel at wr_addr on that edge; wr_en SHALL be ignored outside IDLE.
REQ-009 start=1 in IDLE SHALL enter FEED next cycle; a write in the same cycle SHALL be visible to the run; start outside IDLE SHALL be ignored.
REQ-010 FEED SHALL last F = depth+rows+cols-2 cycles, step counter t = 0..F-1.
REQ-011 At step t, ins slice c SHALL be input entry (t-c), element c, if 0 <= t-c < depth, else 0.
REQ-012 At step t, ws slice r SHALL be weight entry (t-r), element r, if 0 <= t-r < depth, else 0.
REQ-013 At step t, ctls bit (r,c) SHALL be 1 iff t >= depth+r+c; all ctls SHALL be 1 during DRAIN and 0 in IDLE/DONE.
REQ-014 DRAIN SHALL last rows cycles; at drain cycle d, outs SHALL be registered into result row d.
REQ-015 DONE SHALL last one cycle with done=1 and busy=0; busy=1 exactly in FEED and DRAIN.
REQ-016 Latency: start sampled at edge 0, done high in cycle F+rows+1 (13 for defaults).
REQ-017 ins/ws SHALL be 0 in IDLE, DRAIN and DONE; all outputs SHALL be registered except rd_data.
REQ-018 Result buffer SHALL hold its values until the next run's DRAIN overwrites them.
REQ-019 rd_addr >= rows SHALL return all zeros.

Reset
REQ-020 rst=0 at an edge SHALL force IDLE and clear busy, done, ctls, ins, ws, step counters, result buffer, and perf_cycles to 0, including mid-FEED or mid-DRAIN.
REQ-021 Operand buffers SHALL NOT be cleared by reset.

Configuration
REQ-022 With ARRAY_SEQ_PERF_EN defined, perf_cycles SHALL clear on each accepted start, increment once per busy cycle, and saturate at 16'hFFFF.
REQ-023 Without ARRAY_SEQ_PERF_EN, perf_cycles SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-024 All input and weight entries 8'h10 (1.0), start, array model attached -> done at cycle 13, every result element 8'h40 (4.0).
REQ-025 Input entry k = {k+1} for all columns, weights 0 except entry 0 = 8'h10 -> ins column 2 first nonzero at step 2; ctls bit (2,3) rises at step 9; result row r equals input entry 0 scaled.
REQ-026 start asserted during FEED and wr_en during DRAIN -> no restart, buffers unchanged, single done pulse.
REQ-027 rst=0 at FEED step 4 -> next cycle busy=0, ctls=0, ins=0; new start -> full correct run with unchanged operands.
REQ-028 With ARRAY_SEQ_PERF_EN: one run -> perf_cycles = 12; second run -> 12 again (cleared on start); without macro -> 0.
REQ-029 rd_addr = 3 -> rd_data = 0.
